// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: per-channel square-wave outputs and tick strobes.
// Divisors are double-buffered and committed only at a terminal count, on sync, or while the channel is frozen.

module prog_clk_divider_ch #(
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 4,
    parameter int TICK_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             settle,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    output logic             out_clk,
    output logic             tick,
    output logic             pend,
    output logic [WIDTH-1:0] cur
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] pval_q, pval_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             commit;

    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        tick_d = 1'b0;
        cur_d  = cur_q;
        pend_d = pend_q;
        pval_d = pval_q;
        commit = 1'b0;
        if (run) begin
            if (sync) begin
                cnt_d  = '0;
                out_d  = 1'b1;
                commit = pend_q;
            end else if (en) begin
                if (cnt_q == cur_q) begin
                    cnt_d  = '0;
                    out_d  = ~out_q;
                    tick_d = (TICK_MODE == 0) ? 1'b1 : ~out_q;
                    commit = pend_q;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                // Frozen channel: nothing to wait for, so adopt the new divisor now.
                commit = pend_q;
            end
        end
        if (commit) begin
            cur_d  = pval_q;
            pend_d = 1'b0;
        end
        // A write on a commit edge lands after the old pending value moves out.
        if ((run || settle) && wr) begin
            pval_d = din;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            out_q  <= 1'b1;
            tick_q <= 1'b0;
            cur_q  <= WIDTH'(DEFAULT_DIV);
            pend_q <= 1'b0;
            pval_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            cur_q  <= cur_d;
            pend_q <= pend_d;
            pval_q <= pval_d;
        end
    end

    assign out_clk = out_q;
    assign tick    = tick_q;
    assign pend    = pend_q;
    assign cur     = cur_q;
endmodule

module prog_clk_divider #(
    parameter int WIDTH       = 28,
    parameter int NCH         = 2,
    parameter int DEFAULT_DIV = 4,
    parameter int TICK_MODE   = 0
) (
    input  logic                 inClk,
    input  logic                 globalReset,
    input  logic [NCH-1:0]       enable,
    input  logic                 sync,
    input  logic [NCH*WIDTH-1:0] div_in,
    input  logic [NCH-1:0]       div_wr,
    output logic [NCH-1:0]       outClk,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       div_pend,
    output logic [NCH*WIDTH-1:0] div_cur
);
    typedef enum logic [1:0] {ST_RESET, ST_SETTLE, ST_RUN} state_t;

    // state_q is the state of the next cycle in which globalReset is low.
    state_t state_q, state_d, cur_state;
    logic   run, settle;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SETTLE: state_d = ST_RUN;
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_SETTLE;
        endcase
    end

    always_ff @(posedge inClk) begin
        if (globalReset) state_q <= ST_SETTLE;
        else             state_q <= state_d;
    end

    assign cur_state = globalReset ? ST_RESET : state_q;
    assign run       = (cur_state == ST_RUN);
    assign settle    = (cur_state == ST_SETTLE);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        prog_clk_divider_ch #(
            .WIDTH      (WIDTH),
            .DEFAULT_DIV(DEFAULT_DIV),
            .TICK_MODE  (TICK_MODE)
        ) u_ch (
            .clk    (inClk),
            .rst    (globalReset),
            .run    (run),
            .settle (settle),
            .en     (enable[i]),
            .sync   (sync),
            .wr     (div_wr[i]),
            .din    (div_in[i*WIDTH +: WIDTH]),
            .out_clk(outClk[i]),
            .tick   (tick[i]),
            .pend   (div_pend[i]),
            .cur    (div_cur[i*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider: a TICK_MODE=0 instance and a TICK_MODE=1 instance share stimulus.

module tb_prog_clk_divider;
    localparam int W = 8;

    logic         inClk = 1'b0;
    logic         globalReset;
    logic [1:0]   enable;
    logic         sync;
    logic [2*W-1:0] div_in;
    logic [1:0]   div_wr;
    logic [1:0]   out0, tick0, pend0, out1, tick1, pend1;
    logic [2*W-1:0] cur0, cur1;
    int total = 0;
    int bad = 0;

    always #5 inClk = ~inClk;

    prog_clk_divider #(.WIDTH(W), .NCH(2), .DEFAULT_DIV(4), .TICK_MODE(0)) dut0 (
        .inClk(inClk), .globalReset(globalReset), .enable(enable), .sync(sync),
        .div_in(div_in), .div_wr(div_wr), .outClk(out0), .tick(tick0),
        .div_pend(pend0), .div_cur(cur0)
    );

    prog_clk_divider #(.WIDTH(W), .NCH(2), .DEFAULT_DIV(4), .TICK_MODE(1)) dut1 (
        .inClk(inClk), .globalReset(globalReset), .enable(enable), .sync(sync),
        .div_in(div_in), .div_wr(div_wr), .outClk(out1), .tick(tick1),
        .div_pend(pend1), .div_cur(cur1)
    );

    task automatic adv();
        @(posedge inClk);
        #1;
    endtask

    task automatic do_reset();
        globalReset = 1'b1;
        enable      = 2'b11;
        sync        = 1'b0;
        div_wr      = 2'b00;
        div_in      = '0;
        adv();
        adv();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out0 !== 2'b11) begin bad++; $display("FAIL reset_out: got %b want 11", out0); end
        total++; if (tick0 !== 2'b00 || tick1 !== 2'b00) begin bad++; $display("FAIL reset_tick: got %b/%b want 00", tick0, tick1); end
        total++; if (pend0 !== 2'b00) begin bad++; $display("FAIL reset_pend: got %b want 00", pend0); end
        total++; if (cur0 !== {8'd4, 8'd4}) begin bad++; $display("FAIL reset_cur: got %h want 0404", cur0); end
    endtask

    task automatic test_default();
        int t;
        logic expo, tk, tk1;
        do_reset();
        globalReset = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            adv();
            t    = (e >= 6) ? (e - 6) / 5 + 1 : 0;
            expo = (t % 2 == 0);
            tk   = (e >= 6) && ((e - 6) % 5 == 0);
            tk1  = tk && expo;
            total++; if (out0 !== {expo, expo}) begin bad++; $display("FAIL default_out e%0d: got %b want %b%b", e, out0, expo, expo); end
            total++; if (tick0 !== {tk, tk}) begin bad++; $display("FAIL default_tick e%0d: got %b want %b%b", e, tick0, tk, tk); end
            total++; if (tick1 !== {tk1, tk1}) begin bad++; $display("FAIL default_tick_m1 e%0d: got %b want %b%b", e, tick1, tk1, tk1); end
        end
    endtask

    task automatic test_div_write();
        logic [5:0] x0, x1;
        x0 = 6'b100110;  // ch0 after edges 7..12, bit index e-7
        x1 = 6'b110000;
        do_reset();
        globalReset = 1'b0;
        adv(); adv(); adv();
        div_in[W-1:0] = 8'd1;
        div_wr = 2'b01;
        adv();
        div_wr = 2'b00;
        total++; if (pend0 !== 2'b01) begin bad++; $display("FAIL wr_pend_e4: got %b want 01", pend0); end
        total++; if (cur0[W-1:0] !== 8'd4) begin bad++; $display("FAIL wr_cur_e4: got %0d want 4", cur0[W-1:0]); end
        adv();
        total++; if (pend0 !== 2'b01) begin bad++; $display("FAIL wr_pend_e5: got %b want 01", pend0); end
        adv();
        total++; if (cur0 !== {8'd4, 8'd1}) begin bad++; $display("FAIL wr_cur_e6: got %h want 0401", cur0); end
        total++; if (pend0 !== 2'b00) begin bad++; $display("FAIL wr_pend_e6: got %b want 00", pend0); end
        total++; if (out0 !== 2'b00) begin bad++; $display("FAIL wr_out_e6: got %b want 00", out0); end
        for (int e = 7; e <= 12; e++) begin
            adv();
            total++; if (out0 !== {x1[e-7], x0[e-7]}) begin bad++; $display("FAIL wr_out e%0d: got %b want %b%b", e, out0, x1[e-7], x0[e-7]); end
        end
    endtask

    task automatic test_multi_write();
        do_reset();
        globalReset = 1'b0;
        adv(); adv();
        div_in[W-1:0] = 8'd7; div_wr = 2'b01;
        adv();
        div_wr = 2'b00;
        adv();
        div_in[W-1:0] = 8'd2; div_wr = 2'b01;
        adv();
        div_in[W-1:0] = 8'd9; div_wr = 2'b01;
        adv();
        div_wr = 2'b00;
        total++; if (cur0[W-1:0] !== 8'd2) begin bad++; $display("FAIL mw_cur_e6: got %0d want 2", cur0[W-1:0]); end
        total++; if (pend0 !== 2'b01) begin bad++; $display("FAIL mw_pend_e6: got %b want 01", pend0); end
        total++; if (out0[0] !== 1'b0) begin bad++; $display("FAIL mw_out_e6: got %b want 0", out0[0]); end
        adv(); adv();
        total++; if (out0[0] !== 1'b0 || cur0[W-1:0] !== 8'd2) begin bad++; $display("FAIL mw_e8: got out %b cur %0d want out 0 cur 2", out0[0], cur0[W-1:0]); end
        adv();
        total++; if (cur0[W-1:0] !== 8'd9) begin bad++; $display("FAIL mw_cur_e9: got %0d want 9", cur0[W-1:0]); end
        total++; if (pend0 !== 2'b00) begin bad++; $display("FAIL mw_pend_e9: got %b want 00", pend0); end
        total++; if (out0[0] !== 1'b1) begin bad++; $display("FAIL mw_out_e9: got %b want 1", out0[0]); end
    endtask

    task automatic test_div0();
        logic eo, ev;
        do_reset();
        enable = 2'b10;
        div_in[W-1:0] = 8'd0;
        div_wr = 2'b01;
        globalReset = 1'b0;
        adv();
        div_wr = 2'b00;
        total++; if (pend0 !== 2'b01 || pend1 !== 2'b01) begin bad++; $display("FAIL d0_settle_pend: got %b/%b want 01", pend0, pend1); end
        adv();
        total++; if (cur0[W-1:0] !== 8'd0 || pend0 !== 2'b00) begin bad++; $display("FAIL d0_commit: got cur %0d pend %b want cur 0 pend 00", cur0[W-1:0], pend0); end
        total++; if (out0[0] !== 1'b1) begin bad++; $display("FAIL d0_hold: got %b want 1", out0[0]); end
        enable = 2'b11;
        for (int e = 3; e <= 10; e++) begin
            adv();
            ev = (e % 2 == 0);
            eo = ev;
            total++; if (out0[0] !== eo || out1[0] !== eo) begin bad++; $display("FAIL d0_out e%0d: got %b/%b want %b", e, out0[0], out1[0], eo); end
            total++; if (tick0[0] !== 1'b1) begin bad++; $display("FAIL d0_tick_m0 e%0d: got %b want 1", e, tick0[0]); end
            total++; if (tick1[0] !== ev) begin bad++; $display("FAIL d0_tick_m1 e%0d: got %b want %b", e, tick1[0], ev); end
        end
    endtask

    task automatic test_freeze();
        int t;
        logic x1, tk, tk1, x0;
        do_reset();
        globalReset = 1'b0;
        for (int e = 1; e <= 23; e++) begin
            enable[1] = (e >= 8 && e <= 14) ? 1'b0 : 1'b1;
            adv();
            x1  = (e < 6) || (e >= 18 && e < 23);
            tk  = (e == 6) || (e == 18) || (e == 23);
            tk1 = (e == 18);
            t   = (e >= 6) ? (e - 6) / 5 + 1 : 0;
            x0  = (t % 2 == 0);
            total++; if (out0[1] !== x1) begin bad++; $display("FAIL frz_out e%0d: got %b want %b", e, out0[1], x1); end
            total++; if (tick0[1] !== tk || tick1[1] !== tk1) begin bad++; $display("FAIL frz_tick e%0d: got %b/%b want %b/%b", e, tick0[1], tick1[1], tk, tk1); end
            total++; if (out0[0] !== x0) begin bad++; $display("FAIL frz_ch0 e%0d: got %b want %b", e, out0[0], x0); end
        end
        enable = 2'b11;
    endtask

    task automatic test_sync_reset();
        logic [5:0] o0, o1, t0, t1;
        o0 = 6'b000111;  // after edges 9..14, bit index e-9
        o1 = 6'b011111;
        t0 = 6'b001000;
        t1 = 6'b100000;
        do_reset();
        enable = 2'b00;
        div_in = {8'd5, 8'd3};
        div_wr = 2'b11;
        globalReset = 1'b0;
        adv();
        div_wr = 2'b00;
        adv();
        total++; if (cur0 !== {8'd5, 8'd3}) begin bad++; $display("FAIL sy_cur: got %h want 0503", cur0); end
        enable = 2'b11;
        repeat (5) adv();
        total++; if (out0 !== 2'b10) begin bad++; $display("FAIL sy_pre: got %b want 10", out0); end
        sync = 1'b1;
        adv();
        sync = 1'b0;
        total++; if (out0 !== 2'b11 || tick0 !== 2'b00) begin bad++; $display("FAIL sy_edge: got out %b tick %b want 11/00", out0, tick0); end
        for (int e = 9; e <= 14; e++) begin
            adv();
            total++; if (out0 !== {o1[e-9], o0[e-9]}) begin bad++; $display("FAIL sy_out e%0d: got %b want %b%b", e, out0, o1[e-9], o0[e-9]); end
            total++; if (tick0 !== {t1[e-9], t0[e-9]}) begin bad++; $display("FAIL sy_tick e%0d: got %b want %b%b", e, tick0, t1[e-9], t0[e-9]); end
        end
        div_in[W-1:0] = 8'd6;
        div_wr = 2'b01;
        adv();
        div_wr = 2'b00;
        total++; if (pend0 !== 2'b01) begin bad++; $display("FAIL sy_pend: got %b want 01", pend0); end
        globalReset = 1'b1;
        adv();
        total++; if (out0 !== 2'b11 || out1 !== 2'b11) begin bad++; $display("FAIL rst_mid_out: got %b/%b want 11", out0, out1); end
        total++; if (tick0 !== 2'b00 || pend0 !== 2'b00) begin bad++; $display("FAIL rst_mid_tp: got tick %b pend %b want 00/00", tick0, pend0); end
        total++; if (cur0 !== {8'd4, 8'd4}) begin bad++; $display("FAIL rst_mid_cur: got %h want 0404", cur0); end
    endtask

    initial begin
        test_reset();
        test_default();
        test_div_write();
        test_multi_write();
        test_div0();
        test_freeze();
        test_sync_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
